// File: rtl/exu_dmem_resp_pkg.sv
// Shared types, defaults and lane-merge helper for the data-memory responder.
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

package exu_dmem_resp_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 4096;
  localparam logic [31:0] DMEM_BASE_ADDR   = 32'h1000_0000;
  // Buffered word index is held at the widest possible width (32-bit bytes -> 30-bit words)
  // so the struct does not depend on the depth parameter of any one instance.
  localparam int DMEM_WIDX_W = 30;

  typedef struct packed {
    logic                   valid;
    logic [DMEM_WIDX_W-1:0] idx;
    logic [3:0]             mask;
    logic [31:0]            data;
  } dmem_wbuf_t;

  // Replace each byte lane of old_word with new_word where mask selects it.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = mask[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram_1r1w_be.sv
// Word-addressed SRAM with a registered read port and a byte-enabled write port.
// Read-before-write: a same-cycle read and write to one index returns the old word.
module dmem_sram_1r1w_be
  import exu_dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wmask,
  input  logic [31:0]      wdata
);

  logic [31:0] mem_r [0:DEPTH_WORDS-1];
  logic [31:0] rdata_r;

  // Byte-masked write into the array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= lane_merge(mem_r[waddr], wdata, wmask);
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/exu_dmem_resp.sv
// Data-memory responder: one load or store per cycle, one-cycle load latency,
// stores staged through a one-entry write buffer with load forwarding.
module exu_dmem_resp
  import exu_dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_req_i,
  input  logic                       mem_we_i,
  input  logic [`BUS_ADDR_WIDTH-1:0] mem_raddr_i,
  input  logic [`BUS_ADDR_WIDTH-1:0] mem_waddr_i,
  input  logic [3:0]                 mem_wmask_i,
  input  logic [`BUS_DATA_WIDTH-1:0] mem_wdata_i,
  output logic [`BUS_DATA_WIDTH-1:0] mem_rdata_o,
  output logic                       mem_err_o
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

  logic [31:0]      roff_s;
  logic [31:0]      woff_s;
  logic             rd_inr_s;
  logic             wr_inr_s;
  logic [IDX_W-1:0] ridx_s;
  logic [IDX_W-1:0] widx_s;
  logic             load_s;
  logic             store_s;
  logic             re_s;
  logic             hit_s;
  logic             err_s;
  logic [31:0]      sram_rdata_s;

  dmem_wbuf_t  wbuf_r;
  logic [3:0]  fwd_mask_r;
  logic [31:0] fwd_data_r;
  logic        oor_r;
  logic        err_r;

  // Address decode relative to the base, range check and request qualification.
  always_comb begin
    roff_s   = mem_raddr_i - BASE_ADDR;
    woff_s   = mem_waddr_i - BASE_ADDR;
    rd_inr_s = (roff_s < SPAN);
    wr_inr_s = (woff_s < SPAN);
    ridx_s   = roff_s[IDX_W+1:2];
    widx_s   = woff_s[IDX_W+1:2];
    load_s   = mem_req_i & ~mem_we_i;
    store_s  = mem_req_i & mem_we_i;
    re_s     = load_s & rd_inr_s;
    hit_s    = wbuf_r.valid && (wbuf_r.idx == DMEM_WIDX_W'(ridx_s));
    if (mem_req_i) begin
      err_s = mem_we_i ? ~wr_inr_s : ~rd_inr_s;
    end else begin
      err_s = 1'b0;
    end
  end

  // Write buffer: load on an in-range store, otherwise drain (it commits every cycle it is valid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_r <= '0;
    end else if (store_s && wr_inr_s) begin
      wbuf_r.valid <= 1'b1;
      wbuf_r.idx   <= DMEM_WIDX_W'(widx_s);
      wbuf_r.mask  <= mem_wmask_i;
      wbuf_r.data  <= mem_wdata_i;
    end else begin
      wbuf_r <= '0;
    end
  end

  // Capture the forwarding lanes and out-of-range flag alongside each load's array read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_mask_r <= 4'b0000;
      fwd_data_r <= 32'h0000_0000;
      oor_r      <= 1'b0;
    end else if (load_s) begin
      fwd_mask_r <= hit_s ? wbuf_r.mask : 4'b0000;
      fwd_data_r <= wbuf_r.data;
      oor_r      <= ~rd_inr_s;
    end
  end

  // One-cycle error pulse following any out-of-range access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  dmem_sram_1r1w_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (re_s),
    .raddr (ridx_s),
    .rdata (sram_rdata_s),
    .we    (wbuf_r.valid),
    .waddr (wbuf_r.idx[IDX_W-1:0]),
    .wmask (wbuf_r.mask),
    .wdata (wbuf_r.data)
  );

  // Load data: pre-commit array word with buffered lanes merged on top; zero after an out-of-range load.
  always_comb begin
    if (oor_r) begin
      mem_rdata_o = 32'h0000_0000;
    end else begin
      mem_rdata_o = lane_merge(sram_rdata_s, fwd_data_r, fwd_mask_r);
    end
  end

  assign mem_err_o = err_r;

endmodule

// File: tb/tb_exu_dmem_resp.sv
// Self-checking bench: program-order memory model plus directed literal checks and random traffic.
module tb_exu_dmem_resp;
  import exu_dmem_resp_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] SPAN = 32'h0000_4000;

  logic        clk;
  logic        rst_n;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_raddr_i;
  logic [31:0] mem_waddr_i;
  logic [3:0]  mem_wmask_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;

  int checks;
  int errors;

  exu_dmem_resp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_raddr_i (mem_raddr_i),
    .mem_waddr_i (mem_waddr_i),
    .mem_wmask_i (mem_wmask_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_err_o   (mem_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model: memory in program order ----------------
  logic [31:0] mdl_mem   [DEPTH];
  bit          mdl_known [DEPTH];
  logic [31:0] exp_rdata;
  bit          exp_known;
  logic        exp_err;
  bit          pend_valid;
  int          pend_idx;
  logic [31:0] pend_old;
  bit          pend_old_known;
  bit          run_cmp;

  function automatic logic [31:0] bytes_over(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Model: a store becomes visible immediately; a reset before its commit cycle undoes it.
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] off;
    int          idx;
    if (!rst_n) begin
      if (pend_valid) begin
        mdl_mem[pend_idx]   = pend_old;
        mdl_known[pend_idx] = pend_old_known;
      end
      pend_valid = 1'b0;
      exp_rdata  = 32'h0;
      exp_known  = 1'b1;
      exp_err    = 1'b0;
    end else begin
      pend_valid = 1'b0;
      exp_err    = 1'b0;
      if (mem_req_i) begin
        off = (mem_we_i ? mem_waddr_i : mem_raddr_i) - BASE;
        idx = int'(off >> 2);
        if (off >= SPAN) begin
          exp_err = 1'b1;
          if (!mem_we_i) begin
            exp_rdata = 32'h0;
            exp_known = 1'b1;
          end
        end else if (mem_we_i) begin
          pend_valid     = 1'b1;
          pend_idx       = idx;
          pend_old       = mdl_mem[idx];
          pend_old_known = mdl_known[idx];
          mdl_mem[idx]   = bytes_over(mdl_mem[idx], mem_wdata_i, mem_wmask_i);
          if (mem_wmask_i == 4'hF) mdl_known[idx] = 1'b1;
        end else begin
          exp_rdata = mdl_mem[idx];
          exp_known = mdl_known[idx];
        end
      end
    end
  end

  // Compare process: outputs against the model on every cycle, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      checks++;
      if (mem_err_o !== exp_err) begin
        errors++;
        $display("FAIL err: got %b expected %b at %0t", mem_err_o, exp_err, $time);
      end
      if (exp_known) begin
        checks++;
        if (mem_rdata_o !== exp_rdata) begin
          errors++;
          $display("FAIL rdata: got %h expected %h at %0t", mem_rdata_o, exp_rdata, $time);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic op(input logic req, input logic we, input logic [31:0] ra,
                    input logic [31:0] wa, input logic [3:0] m, input logic [31:0] d);
    @(posedge clk);
    #1;
    mem_req_i   = req;
    mem_we_i    = we;
    mem_raddr_i = ra;
    mem_waddr_i = wa;
    mem_wmask_i = m;
    mem_wdata_i = d;
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    op(1'b1, 1'b1, 32'h0, a, m, d);
  endtask

  task automatic ld(input logic [31:0] a);
    op(1'b1, 1'b0, a, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 19);
    if (sel < 16) return BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
    else if (sel == 16) return BASE - 32'd4;
    else if (sel == 17) return BASE + SPAN;
    else if (sel == 18) return BASE + SPAN - 32'd4;
    else return $urandom;
  endfunction

  initial begin
    checks = 0; errors = 0; run_cmp = 1'b0;
    rst_n = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_raddr_i = 32'h0; mem_waddr_i = 32'h0;
    mem_wmask_i = 4'h0; mem_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_lit("reset_rdata", mem_rdata_o, 32'h0);
    check_lit("reset_err", {31'h0, mem_err_o}, 32'h0);
    run_cmp = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;

    // basic store then load
    st(32'h1000_000C, 4'b1111, 32'hDEAD_BEEF); idle(); idle();
    ld(32'h1000_000C); idle(); @(negedge clk);
    check_lit("basic_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    check_lit("basic_err", {31'h0, mem_err_o}, 32'h0);

    // forwarding from the write buffer
    st(32'h1000_0010, 4'b1111, 32'h1122_3344); idle();
    st(32'h1000_0010, 4'b0100, 32'h00AB_0000); ld(32'h1000_0010); idle(); @(negedge clk);
    check_lit("fwd_rdata", mem_rdata_o, 32'h11AB_3344);

    // back-to-back stores to one word
    st(32'h1000_0020, 4'b0011, 32'h0000_5566); st(32'h1000_0020, 4'b1100, 32'h7788_0000);
    ld(32'h1000_0020); idle(); @(negedge clk);
    check_lit("b2b_rdata", mem_rdata_o, 32'h7788_5566);

    // hold after a load
    st(32'h1000_0000, 4'b1111, 32'h1234_5678); idle();
    ld(32'h1000_0000); idle(); @(negedge clk);
    check_lit("hold0", mem_rdata_o, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_lit("hold", mem_rdata_o, 32'h1234_5678);
    end

    // out-of-range load
    ld(32'h0FFF_FFFC); idle(); @(negedge clk);
    check_lit("oor_ld_rdata", mem_rdata_o, 32'h0);
    check_lit("oor_ld_err", {31'h0, mem_err_o}, 32'h1);
    @(negedge clk);
    check_lit("oor_ld_err_pulse", {31'h0, mem_err_o}, 32'h0);

    // out-of-range store must not alias onto word 0
    st(32'h1000_4000, 4'b1111, 32'hFFFF_FFFF); idle(); @(negedge clk);
    check_lit("oor_st_err", {31'h0, mem_err_o}, 32'h1);
    ld(32'h1000_0000); idle(); @(negedge clk);
    check_lit("oor_st_word0", mem_rdata_o, 32'h1234_5678);

    // reset before the buffered store commits discards it
    st(32'h1000_0000, 4'b1111, 32'hCAFE_F00D);
    @(posedge clk); #1;
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_lit("rst_mid_rdata", mem_rdata_o, 32'h0);
    check_lit("rst_mid_err", {31'h0, mem_err_o}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    ld(32'h1000_0000); idle(); @(negedge clk);
    check_lit("rst_discard", mem_rdata_o, 32'h1234_5678);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int kind;
      logic [3:0] m;
      kind = $urandom_range(0, 9);
      m = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      if (kind < 4) op(1'b1, 1'b1, $urandom, rand_addr(), m, $urandom);
      else if (kind < 8) op(1'b1, 1'b0, rand_addr(), $urandom, m, $urandom);
      else op(1'b0, 1'($urandom_range(0, 1)), rand_addr(), rand_addr(), m, $urandom);
    end
    idle(); idle();
    @(negedge clk);
    run_cmp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
